// File: rtl/fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_arbiter
//  Description : Round-robin read scheduler. Drains PORT_COUNT FIFO read
//                sides into a single egress stream. One port is granted at a
//                time. A grant lasts for one whole packet, or for at most
//                MAX_BURST_WORDS words, and then arbitration runs again.
//                Egress is registered through a 2-entry skid buffer.
//  Ports       : clock, reset_n            - clock, async active-low reset
//                fifo_empty                - per-port empty flags
//                fifo_read_data            - packed per-port head words
//                fifo_read_data_valid      - per-port head-word-valid flags
//                fifo_read_enable          - per-port pop strobes (one-hot0)
//                out_data/out_port         - egress word and its source port
//                out_valid/out_ready       - egress handshake
//                busy                      - grant in progress
//                burst_truncated           - grant ended on the burst limit
//                                            without end-of-packet
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_arbiter #(
    parameter int PORT_COUNT      = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int LAST_BIT        = 15,
    parameter int MAX_BURST_WORDS = 256
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [PORT_COUNT-1:0]            fifo_empty,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0] fifo_read_data,
    input  logic [PORT_COUNT-1:0]            fifo_read_data_valid,
    output logic [PORT_COUNT-1:0]            fifo_read_enable,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [$clog2(PORT_COUNT)-1:0]    out_port,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             burst_truncated
);

    localparam int c_port_w = $clog2(PORT_COUNT);
    localparam int c_cnt_w  = $clog2(MAX_BURST_WORDS + 1);
    localparam logic [c_cnt_w-1:0] c_max_burst = c_cnt_w'(MAX_BURST_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRANSFER = 2'd1,
        ST_RELEASE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_port_w-1:0]   r_grant;
    logic [c_port_w-1:0]   r_last_grant;
    logic [c_cnt_w-1:0]    r_word_count;
    logic                  r_trunc;

    // Skid buffer storage: two entries addressed by a 1-bit head pointer.
    logic [DATA_WIDTH-1:0] r_skid_data [2];
    logic [c_port_w-1:0]   r_skid_port [2];
    logic                  r_skid_head;
    logic [1:0]            r_skid_count;

    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_can_accept;
    logic                  w_consume;
    logic                  w_is_last;
    logic                  w_at_limit;
    logic                  w_found;
    logic [c_port_w-1:0]   w_pick;
    logic [c_port_w-1:0]   w_idx;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_wr_ptr;

    assign w_sel_data   = fifo_read_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
    assign w_can_accept = (r_skid_count != 2'd2);
    assign w_consume    = (r_state == ST_TRANSFER) && w_can_accept
                          && fifo_read_data_valid[r_grant];
    assign w_is_last    = w_sel_data[LAST_BIT];
    assign w_at_limit   = ((r_word_count + c_cnt_w'(1)) == c_max_burst);

    // Round-robin pick: first non-empty port strictly after the last grant.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= PORT_COUNT; k++) begin
            w_idx = c_port_w'((int'(r_last_grant) + k) % PORT_COUNT);
            if (!w_found && !fifo_empty[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Next-state and FSM-decoded outputs.
    always_comb begin
        w_state_next     = r_state;
        fifo_read_enable = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next = ST_TRANSFER;
                end
            end
            ST_TRANSFER: begin
                // Popping only while the skid buffer has room means it can
                // never overflow, so no back-pressure path is needed.
                fifo_read_enable[r_grant] = w_can_accept;
                if (w_consume && (w_is_last || w_at_limit)) begin
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy            = (r_state != ST_IDLE);
    assign burst_truncated = (r_state == ST_RELEASE) && r_trunc;

    // Control state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_port_w'(PORT_COUNT - 1);
            r_word_count <= '0;
            r_trunc      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_found) begin
                r_grant      <= w_pick;
                r_word_count <= '0;
                r_trunc      <= 1'b0;
            end
            if (w_consume) begin
                r_word_count <= r_word_count + c_cnt_w'(1);
                // Truncation is only flagged if the limit, not the
                // end-of-packet marker, ended the grant.
                if (w_is_last || w_at_limit) begin
                    r_trunc <= w_at_limit && !w_is_last;
                end
            end
            if (r_state == ST_RELEASE) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Skid buffer.
    assign w_push   = w_consume;
    assign w_pop    = (r_skid_count != 2'd0) && out_ready;
    // With one entry held, the new word goes into the slot after the head.
    assign w_wr_ptr = r_skid_head ^ (r_skid_count == 2'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < 2; e++) begin
                r_skid_data[e] <= '0;
                r_skid_port[e] <= '0;
            end
            r_skid_head  <= 1'b0;
            r_skid_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_skid_data[w_wr_ptr] <= w_sel_data;
                r_skid_port[w_wr_ptr] <= r_grant;
            end
            if (w_pop) begin
                r_skid_head <= ~r_skid_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_skid_count <= r_skid_count + 2'd1;
                2'b01:   r_skid_count <= r_skid_count - 2'd1;
                default: r_skid_count <= r_skid_count;
            endcase
        end
    end

    assign out_valid = (r_skid_count != 2'd0);
    assign out_data  = r_skid_data[r_skid_head];
    assign out_port  = r_skid_port[r_skid_head];

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_read_arbiter
//  Description : Self-checking bench for fifo_read_arbiter. Per-port FIFO
//                models feed the DUT. Expected egress words are queued when
//                packets are loaded and are compared when the DUT emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_arbiter;

    localparam int NP = 4;
    localparam int DW = 16;

    logic            clock;
    logic            reset_n;
    logic [NP-1:0]   fifo_empty;
    logic [NP*DW-1:0] fifo_read_data;
    logic [NP-1:0]   fifo_read_data_valid;
    logic [NP-1:0]   fifo_read_enable;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_port;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            burst_truncated;

    fifo_read_arbiter #(
        .PORT_COUNT     (NP),
        .DATA_WIDTH     (DW),
        .LAST_BIT       (15),
        .MAX_BURST_WORDS(4)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .fifo_empty          (fifo_empty),
        .fifo_read_data      (fifo_read_data),
        .fifo_read_data_valid(fifo_read_data_valid),
        .fifo_read_enable    (fifo_read_enable),
        .out_data            (out_data),
        .out_port            (out_port),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .busy                (busy),
        .burst_truncated     (burst_truncated)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [15:0] pq [NP][$];
    logic [17:0] exp_q [$];
    logic [NP-1:0] vmask;
    int n_tests = 0;
    int n_fail  = 0;
    int cons_cnt = 0;
    int en_cnt = 0;
    int trunc_cnt = 0;
    int cyc = 0;
    int first_cons = -1;
    int last_cons = -1;

    typedef struct {
        int port;
        int len;
        int trunc;
    } vec_t;
    vec_t vt [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NP; i++) begin
            fifo_empty[i] = (pq[i].size() == 0);
            fifo_read_data[i*DW +: DW] = (pq[i].size() != 0) ? pq[i][0] : 16'h0;
            fifo_read_data_valid[i] = (pq[i].size() != 0) && vmask[i];
        end
    endtask

    task automatic push_word(input int port, input logic [15:0] w);
        pq[port].push_back(w);
        exp_q.push_back({2'(port), w});
    endtask

    // Packet words carry a tag and word index; only the last has bit 15 set.
    task automatic load_packet(input int port, input int len, input int tag);
        logic [15:0] w;
        for (int k = 0; k < len; k++) begin
            w = {(k == len - 1), 7'(tag), 8'(k)};
            push_word(port, w);
        end
        refresh();
    endtask

    task automatic clear_counts();
        cons_cnt = 0; en_cnt = 0; trunc_cnt = 0; first_cons = -1; last_cons = -1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        for (int i = 0; i < NP; i++) pq[i].delete();
        exp_q.delete();
        refresh();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !busy && !out_valid &&
                pq[0].size() == 0 && pq[1].size() == 0 &&
                pq[2].size() == 0 && pq[3].size() == 0)
                done = 1'b1;
        end
        check({name, "_drain_done"}, 32'(done), 32'd1);
    endtask

    task automatic wait_cons(input string name, input int n);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clock);
            if (cons_cnt >= n) done = 1'b1;
        end
        check({name, "_wait_consume"}, 32'(done), 32'd1);
    endtask

    // Monitor: samples just before each rising edge, then applies FIFO pops
    // just after it.
    always @(negedge clock) begin
        logic [NP-1:0] pm;
        logic [17:0]   e;
        #4;
        cyc++;
        pm = fifo_read_enable & fifo_read_data_valid;
        if (reset_n) begin
            check("enable_onehot0", 32'($onehot0(fifo_read_enable)), 32'd1);
            if (fifo_read_enable != '0) en_cnt++;
            if (burst_truncated) trunc_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got port %0d data 0x%0h, required no output",
                             out_port, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", 32'(out_data), 32'(e[15:0]));
                    check("sb_port", 32'(out_port), 32'(e[17:16]));
                end
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (pm[i] && pq[i].size() != 0) begin
                void'(pq[i].pop_front());
                cons_cnt++;
                if (first_cons < 0) first_cons = cyc;
                last_cons = cyc;
            end
        end
        refresh();
    end

    initial begin
        vt[0] = '{port: 2, len: 3, trunc: 0};
        vt[1] = '{port: 0, len: 1, trunc: 0};
        vt[2] = '{port: 3, len: 4, trunc: 0};
        vt[3] = '{port: 1, len: 6, trunc: 1};
        vt[4] = '{port: 2, len: 5, trunc: 1};

        reset_n   = 1'b0;
        out_ready = 1'b1;
        vmask     = '1;
        refresh();
        #1;
        check("rst_enable",   32'(fifo_read_enable), 32'd0);
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_data",     32'(out_data), 32'd0);
        check("rst_port",     32'(out_port), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_trunc",    32'(burst_truncated), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Single 3-word packet on port 2.
        @(negedge clock);
        clear_counts();
        push_word(2, 16'h0011);
        push_word(2, 16'h0022);
        push_word(2, 16'h8033);
        refresh();
        wait_cons("p2", 3);
        check("p2_busy_release", 32'(busy), 32'd1);
        check("p2_enable_release", 32'(fifo_read_enable), 32'd0);
        @(negedge clock);
        check("p2_busy_idle", 32'(busy), 32'd0);
        wait_drain("p2");
        check("p2_en_cycles", 32'(en_cnt), 32'd3);
        check("p2_throughput", 32'(last_cons - first_cons), 32'd2);

        // Table of single-packet cases, including burst-limit boundaries.
        for (int t = 0; t < 5; t++) begin
            @(negedge clock);
            clear_counts();
            load_packet(vt[t].port, vt[t].len, 16 + t);
            wait_drain("tbl");
            check("tbl_consumed", 32'(cons_cnt), 32'(vt[t].len));
            check("tbl_trunc", 32'(trunc_cnt), 32'(vt[t].trunc));
        end

        // Grant order after reset: 0, 1, 3, then wrap to 0 and 1.
        do_reset();
        @(negedge clock);
        clear_counts();
        load_packet(0, 2, 40);
        load_packet(1, 2, 41);
        load_packet(3, 2, 43);
        wait_drain("order");
        check("order_consumed", 32'(cons_cnt), 32'd6);
        @(negedge clock);
        load_packet(0, 2, 50);
        load_packet(1, 2, 51);
        wait_drain("wrap");

        // Egress back-pressure: only two words fit before pops stop.
        @(negedge clock);
        clear_counts();
        out_ready = 1'b0;
        load_packet(0, 4, 60);
        repeat (10) @(negedge clock);
        check("stall_consumed", 32'(cons_cnt), 32'd2);
        check("stall_enable", 32'(fifo_read_enable), 32'd0);
        check("stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_drain("stall");
        check("stall_total", 32'(cons_cnt), 32'd4);

        // Intermittent head-word-valid on the granted port.
        @(negedge clock);
        clear_counts();
        load_packet(0, 4, 70);
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            vmask[0] = ~vmask[0];
            refresh();
        end
        vmask = '1;
        refresh();
        wait_drain("toggle");
        check("toggle_consumed", 32'(cons_cnt), 32'd4);
        check("toggle_trunc", 32'(trunc_cnt), 32'd0);

        // Reset in the middle of a packet on port 3.
        @(negedge clock);
        clear_counts();
        load_packet(3, 4, 80);
        wait_cons("mid", 2);
        reset_n = 1'b0;
        for (int i = 0; i < NP; i++) pq[i].delete();
        exp_q.delete();
        refresh();
        #1;
        check("mid_rst_enable", 32'(fifo_read_enable), 32'd0);
        check("mid_rst_valid",  32'(out_valid), 32'd0);
        check("mid_rst_data",   32'(out_data), 32'd0);
        check("mid_rst_port",   32'(out_port), 32'd0);
        check("mid_rst_busy",   32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        load_packet(1, 2, 90);
        load_packet(3, 2, 93);
        wait_drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
